// File: rtl/writeback_pkg.sv
// Shared types and sizing helpers for the register-file writeback queue.
package writeback_pkg;

   localparam int unsigned WB_DATA_WIDTH    = 32;
   localparam int unsigned WB_ADDRESS_WIDTH = 5;

   typedef struct packed {
      logic [WB_ADDRESS_WIDTH-1:0] address;
      logic [WB_DATA_WIDTH-1:0]    data;
   } writeback_entry_t;

   // Count must represent 0..DEPTH inclusive.
   function automatic int unsigned count_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/writeback_fifo_storage.sv
// Entry array for the writeback queue: two write ports (distinct slots per cycle)
// and one asynchronous read port for the head entry. No reset on storage.
module writeback_fifo_storage
   import writeback_pkg::*;
#(
   parameter int unsigned DEPTH   = 4,
   parameter type         entry_t = writeback_entry_t,
   localparam int unsigned PW     = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          write_a,
   input  logic [PW-1:0] index_a,
   input  entry_t        entry_a,
   input  logic          write_b,
   input  logic [PW-1:0] index_b,
   input  entry_t        entry_b,
   input  logic [PW-1:0] read_index,
   output entry_t        read_entry
);

   entry_t storage [DEPTH];

   always_ff @(posedge clk) begin
      if (write_a) storage[index_a] <= entry_a;
      if (write_b) storage[index_b] <= entry_b;
   end

   assign read_entry = storage[read_index];

endmodule

// File: rtl/register_writeback_queue.sv
// Serialises ALU and load results onto the register file's single write port
// through a small in-order FIFO with valid/ready back-pressure.
module register_writeback_queue
   import writeback_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = WB_DATA_WIDTH,
   parameter int unsigned ADDRESS_WIDTH = WB_ADDRESS_WIDTH,
   parameter int unsigned DEPTH         = 4
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          alu_valid,
   output logic                          alu_ready,
   input  logic [ADDRESS_WIDTH-1:0]      alu_address,
   input  logic [DATA_WIDTH-1:0]         alu_data,
   input  logic                          memory_valid,
   output logic                          memory_ready,
   input  logic [ADDRESS_WIDTH-1:0]      memory_address,
   input  logic [DATA_WIDTH-1:0]         memory_data,
   output logic                          write_enable,
   output logic [ADDRESS_WIDTH-1:0]      address_1,
   output logic [DATA_WIDTH-1:0]         write_data,
   output logic [count_width(DEPTH)-1:0] occupancy,
   output logic                          empty
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = count_width(DEPTH);
   localparam logic [CW-1:0] ALU_LIMIT    = CW'(DEPTH - 1);
   localparam logic [CW-1:0] MEMORY_LIMIT = CW'(DEPTH - 2);

   typedef struct packed {
      logic [ADDRESS_WIDTH-1:0] address;
      logic [DATA_WIDTH-1:0]    data;
   } queue_entry_t;

   logic [CW-1:0] count;
   logic [PW-1:0] read_ptr;
   logic [PW-1:0] write_ptr;
   logic          alu_take;
   logic          memory_take;
   logic          pop;
   logic [PW-1:0] memory_index;
   queue_entry_t  alu_entry;
   queue_entry_t  memory_entry;
   queue_entry_t  head_entry;

   // Readiness looks only at the registered count so a valid never feeds back into ready;
   // the memory limit leaves room for both producers to land in the same cycle.
   assign alu_ready    = (count <= ALU_LIMIT);
   assign memory_ready = (count <= MEMORY_LIMIT);
   assign alu_take     = alu_valid && alu_ready;
   assign memory_take  = memory_valid && memory_ready;
   assign pop          = (count != '0);

   assign memory_index = alu_take ? write_ptr + PW'(1) : write_ptr;
   assign alu_entry    = '{address: alu_address, data: alu_data};
   assign memory_entry = '{address: memory_address, data: memory_data};

   writeback_fifo_storage #(
      .DEPTH   (DEPTH),
      .entry_t (queue_entry_t)
   ) u_storage (
      .clk        (clk),
      .write_a    (alu_take),
      .index_a    (write_ptr),
      .entry_a    (alu_entry),
      .write_b    (memory_take),
      .index_b    (memory_index),
      .entry_b    (memory_entry),
      .read_index (read_ptr),
      .read_entry (head_entry)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count     <= '0;
         read_ptr  <= '0;
         write_ptr <= '0;
      end else begin
         count     <= count + CW'(alu_take) + CW'(memory_take) - CW'(pop);
         read_ptr  <= read_ptr + PW'(pop);
         write_ptr <= write_ptr + PW'(alu_take) + PW'(memory_take);
      end
   end

   assign write_enable = pop;
   assign address_1    = pop ? head_entry.address : '0;
   assign write_data   = pop ? head_entry.data : '0;
   assign occupancy    = count;
   assign empty        = (count == '0);

endmodule

// File: tb/tb_register_writeback_queue.sv
// Directed self-checking bench for register_writeback_queue (DEPTH=4).
module tb_register_writeback_queue;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        alu_valid;
   logic        alu_ready;
   logic [4:0]  alu_address;
   logic [31:0] alu_data;
   logic        memory_valid;
   logic        memory_ready;
   logic [4:0]  memory_address;
   logic [31:0] memory_data;
   logic        write_enable;
   logic [4:0]  address_1;
   logic [31:0] write_data;
   logic [2:0]  occupancy;
   logic        empty;

   int unsigned checks = 0;
   int unsigned errors = 0;
   logic [31:0] shadow [32] = '{default: '0};

   register_writeback_queue #(
      .DATA_WIDTH    (32),
      .ADDRESS_WIDTH (5),
      .DEPTH         (4)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .alu_valid      (alu_valid),
      .alu_ready      (alu_ready),
      .alu_address    (alu_address),
      .alu_data       (alu_data),
      .memory_valid   (memory_valid),
      .memory_ready   (memory_ready),
      .memory_address (memory_address),
      .memory_data    (memory_data),
      .write_enable   (write_enable),
      .address_1      (address_1),
      .write_data     (write_data),
      .occupancy      (occupancy),
      .empty          (empty)
   );

   always #5 clk = ~clk;

   // Stand-in for data_register_file: records every committed write.
   always @(posedge clk) begin
      if (write_enable) shadow[address_1] <= write_data;
   end

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      check("occupancy_bound", 32'(occupancy <= 3'd4), 32'd1);
   endtask

   task automatic set_alu(input logic v, input logic [4:0] a, input logic [31:0] d);
      alu_valid = v; alu_address = a; alu_data = d;
   endtask

   task automatic set_memory(input logic v, input logic [4:0] a, input logic [31:0] d);
      memory_valid = v; memory_address = a; memory_data = d;
   endtask

   task automatic check_head(input string tag, input logic [2:0] occ, input logic [4:0] a, input logic [31:0] d);
      check({tag, "_occupancy"}, 32'(occupancy), 32'(occ));
      check({tag, "_write_enable"}, 32'(write_enable), 32'd1);
      check({tag, "_address"}, 32'(address_1), 32'(a));
      check({tag, "_data"}, write_data, d);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_write_enable"}, 32'(write_enable), 32'd0);
      check({tag, "_empty"}, 32'(empty), 32'd1);
      check({tag, "_occupancy"}, 32'(occupancy), 32'd0);
      check({tag, "_address"}, 32'(address_1), 32'd0);
      check({tag, "_data"}, write_data, 32'd0);
   endtask

   initial begin
      reset_n = 1'b0;
      set_alu(1'b0, 5'd0, 32'h0);
      set_memory(1'b0, 5'd0, 32'h0);
      #1;
      check_idle("reset");
      check("reset_alu_ready", 32'(alu_ready), 32'd1);
      check("reset_memory_ready", 32'(memory_ready), 32'd1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      check_idle("post_reset");

      // Single ALU write
      set_alu(1'b1, 5'd3, 32'hA5);
      tick();
      set_alu(1'b0, 5'd0, 32'h0);
      check_head("single", 3'd1, 5'd3, 32'hA5);
      check("single_empty", 32'(empty), 32'd0);
      tick();
      check_idle("single_drained");

      // Simultaneous producers: ALU ordered first
      set_alu(1'b1, 5'd1, 32'h11);
      set_memory(1'b1, 5'd2, 32'h22);
      tick();
      set_alu(1'b0, 5'd0, 32'h0);
      set_memory(1'b0, 5'd0, 32'h0);
      check_head("dual_first", 3'd2, 5'd1, 32'h11);
      tick();
      check_head("dual_second", 3'd1, 5'd2, 32'h22);
      tick();
      check_idle("dual_drained");

      // Fill: producers hold payload until accepted
      set_alu(1'b1, 5'd10, 32'hA0);
      set_memory(1'b1, 5'd20, 32'hB0);
      tick();
      check_head("fill1", 3'd2, 5'd10, 32'hA0);
      check("fill1_memory_ready", 32'(memory_ready), 32'd1);
      set_alu(1'b1, 5'd11, 32'hA1);
      set_memory(1'b1, 5'd21, 32'hB1);
      tick();
      check_head("fill2", 3'd3, 5'd20, 32'hB0);
      check("fill2_memory_ready", 32'(memory_ready), 32'd0);
      check("fill2_alu_ready", 32'(alu_ready), 32'd1);
      set_alu(1'b1, 5'd12, 32'hA2);
      set_memory(1'b1, 5'd22, 32'hB2);
      tick();
      check_head("fill3", 3'd3, 5'd11, 32'hA1);
      check("fill3_memory_ready", 32'(memory_ready), 32'd0);
      set_alu(1'b0, 5'd0, 32'h0);
      tick();
      check_head("fill4", 3'd2, 5'd21, 32'hB1);
      check("fill4_memory_ready", 32'(memory_ready), 32'd1);
      tick();
      set_memory(1'b0, 5'd0, 32'h0);
      check_head("fill5", 3'd2, 5'd12, 32'hA2);
      tick();
      check_head("fill6", 3'd1, 5'd22, 32'hB2);
      tick();
      check_idle("fill_drained");

      // Same address: last arrival wins
      set_alu(1'b1, 5'd7, 32'h1);
      set_memory(1'b1, 5'd7, 32'h2);
      tick();
      set_alu(1'b0, 5'd0, 32'h0);
      set_memory(1'b0, 5'd0, 32'h0);
      check_head("same_first", 3'd2, 5'd7, 32'h1);
      tick();
      check_head("same_second", 3'd1, 5'd7, 32'h2);
      tick();
      check_idle("same_drained");
      check("same_register7", shadow[7], 32'h2);

      // Pointer wrap: 12 back-to-back ALU results
      for (int i = 0; i < 12; i++) begin
         set_alu(1'b1, 5'((i % 8) + 1), 32'(i));
         tick();
         check_head("wrap", 3'd1, 5'((i % 8) + 1), 32'(i));
      end
      set_alu(1'b0, 5'd0, 32'h0);
      tick();
      check_idle("wrap_drained");

      // Reset mid-stream with 3 entries queued
      set_alu(1'b1, 5'd13, 32'hC0);
      set_memory(1'b1, 5'd14, 32'hD0);
      tick();
      set_alu(1'b1, 5'd15, 32'hC1);
      set_memory(1'b1, 5'd16, 32'hD1);
      tick();
      set_alu(1'b0, 5'd0, 32'h0);
      set_memory(1'b0, 5'd0, 32'h0);
      check("midreset_loaded", 32'(occupancy), 32'd3);
      #2;
      reset_n = 1'b0;
      #1;
      check_idle("midreset_async");
      check("midreset_alu_ready", 32'(alu_ready), 32'd1);
      check("midreset_memory_ready", 32'(memory_ready), 32'd1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_idle("midreset_no_stale");
      end
      check("midreset_register15", shadow[15], 32'h0);

      // Queue still works after reset
      set_alu(1'b1, 5'd5, 32'h55);
      tick();
      set_alu(1'b0, 5'd0, 32'h0);
      check_head("after_reset", 3'd1, 5'd5, 32'h55);
      tick();
      check_idle("after_reset_drained");
      check("after_reset_register5", shadow[5], 32'h55);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
